// File: rtl/axis_uart_rx.sv
// UART receiver packing DATA_BITS-wide frames into AXI-Stream words, first byte in the MSBs.
// Define AXIS_UART_RX_PARITY_CHECK_EN to enable parity checking; otherwise parity_err is tied 0.
module axis_uart_rx #(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int CLOCK          = 100_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_BITS    = 0
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      uart_rx,
    output logic                      rx_done,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overrun_err,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int COUNT_SPEED = CLOCK / BAUD_RATE;
    localparam int HALF        = COUNT_SPEED / 2;
    localparam int DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
    localparam int BAUD_W      = (COUNT_SPEED > 1) ? $clog2(COUNT_SPEED) : 1;
    localparam int BIT_W       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int BYTE_W      = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(COUNT_SPEED - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(DATA_BYTE - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    if ((STOP_BITS < 1) || (STOP_BITS > 2) || (PARITY_BITS < 0) || (PARITY_BITS > 1) ||
        (DATA_BITS < 1) || ((AXI_DATA_WIDTH % DATA_BITS) != 0) || (COUNT_SPEED < 2)) begin : g_bad_config
        $error("axis_uart_rx: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state;
    logic                      rx_meta;
    logic                      rx_sync;
    logic [BAUD_W-1:0]         count_baud;
    logic [BIT_W-1:0]          count_bit;
    logic                      count_stop;
    logic [BYTE_W-1:0]         count_byte;
    logic [DATA_BITS-1:0]      data_byte;
    logic [AXI_DATA_WIDTH-1:0] word;
    logic [AXI_DATA_WIDTH-1:0] word_next;
    logic                      word_done;
    logic                      frame_acc;
    logic                      frame_pend;
    logic                      frame_now;
    logic                      baud_tick;

    assign baud_tick = (count_baud == BAUD_LAST);
    assign frame_now = frame_acc | ~rx_sync;

    // A single-byte word has no older bytes to keep, so the shift degenerates to a load.
    if (DATA_BYTE == 1) begin : g_word_single
        assign word_next = data_byte;
    end else begin : g_word_multi
        assign word_next = {word[AXI_DATA_WIDTH-DATA_BITS-1:0], data_byte};
    end

`ifdef AXIS_UART_RX_PARITY_CHECK_EN
    logic parity_acc;
    logic parity_pend;
    logic parity_expected;

    assign parity_expected = (PARITY_BITS != 0) ? (^data_byte) : ~(^data_byte);
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            state         <= IDLE;
            count_baud    <= '0;
            count_bit     <= '0;
            count_stop    <= 1'b0;
            count_byte    <= '0;
            data_byte     <= '0;
            word          <= '0;
            word_done     <= 1'b0;
            frame_acc     <= 1'b0;
            frame_pend    <= 1'b0;
            rx_done       <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_CHECK_EN
            parity_acc    <= 1'b0;
            parity_pend   <= 1'b0;
            parity_err    <= 1'b0;
`endif
        end else begin
            rx_meta     <= uart_rx;
            rx_sync     <= rx_meta;
            word_done   <= 1'b0;
            rx_done     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_CHECK_EN
            parity_err  <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state      <= START;
                        count_baud <= '0;
                    end
                end

                // Re-check the start bit at its midpoint so short low glitches are rejected.
                START: begin
                    if (count_baud == HALF_LAST) begin
                        count_baud <= '0;
                        count_bit  <= '0;
                        state      <= rx_sync ? IDLE : DATA;
                    end else begin
                        count_baud <= count_baud + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        count_baud           <= '0;
                        data_byte[count_bit] <= rx_sync;
                        if (count_bit == BIT_LAST) begin
                            count_bit <= '0;
                            state     <= PARITY;
                        end else begin
                            count_bit <= count_bit + BIT_W'(1);
                        end
                    end else begin
                        count_baud <= count_baud + BAUD_W'(1);
                    end
                end

                PARITY: begin
                    if (baud_tick) begin
                        count_baud <= '0;
                        count_stop <= 1'b0;
                        state      <= STOP;
`ifdef AXIS_UART_RX_PARITY_CHECK_EN
                        if (rx_sync != parity_expected) begin
                            parity_acc <= 1'b1;
                        end
`endif
                    end else begin
                        count_baud <= count_baud + BAUD_W'(1);
                    end
                end

                // Return to IDLE right after the last stop sample so the next start edge is not missed.
                STOP: begin
                    if (baud_tick) begin
                        count_baud <= '0;
                        if (count_stop == STOP_LAST) begin
                            count_stop <= 1'b0;
                            word       <= word_next;
                            state      <= IDLE;
                            if (count_byte == BYTE_LAST) begin
                                count_byte  <= '0;
                                word_done   <= 1'b1;
                                frame_pend  <= frame_now;
                                frame_acc   <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_CHECK_EN
                                parity_pend <= parity_acc;
                                parity_acc  <= 1'b0;
`endif
                            end else begin
                                count_byte <= count_byte + BYTE_W'(1);
                                frame_acc  <= frame_now;
                            end
                        end else begin
                            count_stop <= 1'b1;
                            frame_acc  <= frame_now;
                        end
                    end else begin
                        count_baud <= count_baud + BAUD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // A finished word replaces the output only if the previous one is gone or leaving now.
            if (word_done) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= word;
                    m_axis_tvalid <= 1'b1;
                    rx_done       <= 1'b1;
                    frame_err     <= frame_pend;
`ifdef AXIS_UART_RX_PARITY_CHECK_EN
                    parity_err    <= parity_pend;
`endif
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Scoreboard bench for axis_uart_rx: an 8-bit-word instance and a 16-bit-word instance at 10 clocks per bit.
module tb_axis_uart_rx;

    localparam int BIT_CLKS = 10;

`ifdef AXIS_UART_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        perr;
        logic        ferr;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset8 = 1'b1;
    logic        areset16 = 1'b1;
    logic        uart8 = 1'b1;
    logic        uart16 = 1'b1;
    logic        tready8 = 1'b1;
    logic        tready16 = 1'b1;

    logic        rx_done8, parity_err8, frame_err8, overrun_err8, tvalid8;
    logic [7:0]  tdata8;
    logic        rx_done16, parity_err16, frame_err16, overrun_err16, tvalid16;
    logic [15:0] tdata16;

    exp_t        done8_q[$];
    exp_t        done16_q[$];
    logic [7:0]  hs8_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int ovr_exp = 0;
    int ovr_seen = 0;

    always #5 aclk = ~aclk;

    axis_uart_rx #(
        .AXI_DATA_WIDTH(8), .CLOCK(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
    ) dut8 (
        .aclk(aclk), .areset(areset8), .uart_rx(uart8),
        .rx_done(rx_done8), .parity_err(parity_err8), .frame_err(frame_err8),
        .overrun_err(overrun_err8), .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8),
        .m_axis_tready(tready8)
    );

    axis_uart_rx #(
        .AXI_DATA_WIDTH(16), .CLOCK(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
    ) dut16 (
        .aclk(aclk), .areset(areset16), .uart_rx(uart16),
        .rx_done(rx_done16), .parity_err(parity_err16), .frame_err(frame_err16),
        .overrun_err(overrun_err16), .m_axis_tdata(tdata16), .m_axis_tvalid(tvalid16),
        .m_axis_tready(tready16)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveLine(input bit sel16, input logic value, input int clks);
        if (sel16) uart16 = value;
        else       uart8  = value;
        repeat (clks) @(posedge aclk);
        #1;
    endtask

    // One full frame: start, 8 data bits LSB first, parity, stop, then an idle gap.
    task automatic applyStimulus(input bit sel16, input logic [7:0] data, input logic par, input logic stop);
        @(posedge aclk);
        #1;
        driveLine(sel16, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            driveLine(sel16, data[i], BIT_CLKS);
        end
        driveLine(sel16, par, BIT_CLKS);
        driveLine(sel16, stop, BIT_CLKS);
        driveLine(sel16, 1'b1, 2 * BIT_CLKS);
    endtask

    task automatic pushWord8(input logic [7:0] data, input logic perr, input logic ferr);
        exp_t e;
        e.data = {8'h00, data};
        e.perr = perr;
        e.ferr = ferr;
        done8_q.push_back(e);
        hs8_q.push_back(data);
    endtask

    task automatic pushWord16(input logic [15:0] data);
        exp_t e;
        e.data = data;
        e.perr = 1'b0;
        e.ferr = 1'b0;
        done16_q.push_back(e);
    endtask

    // Monitor: every completion or handshake the DUTs present is matched against the scoreboard.
    always @(negedge aclk) begin
        exp_t e;
        if (!areset8) begin
            if (rx_done8) begin
                if (done8_q.size() == 0) begin
                    checkOutput("unexpected_done8", {24'h0, tdata8}, 32'hFFFF_FFFF);
                end else begin
                    e = done8_q.pop_front();
                    checkOutput("tdata8", {24'h0, tdata8}, {16'h0, e.data});
                    checkOutput("parity_err8", {31'h0, parity_err8}, {31'h0, e.perr});
                    checkOutput("frame_err8", {31'h0, frame_err8}, {31'h0, e.ferr});
                end
            end
            if (tvalid8 && tready8) begin
                if (hs8_q.size() == 0) begin
                    checkOutput("unexpected_hs8", {24'h0, tdata8}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("hs_tdata8", {24'h0, tdata8}, {24'h0, hs8_q.pop_front()});
                end
            end
            if (overrun_err8) ovr_seen++;
        end
        if (!areset16) begin
            if (rx_done16) begin
                if (done16_q.size() == 0) begin
                    checkOutput("unexpected_done16", {16'h0, tdata16}, 32'hFFFF_FFFF);
                end else begin
                    e = done16_q.pop_front();
                    checkOutput("tdata16", {16'h0, tdata16}, {16'h0, e.data});
                    checkOutput("frame_err16", {31'h0, frame_err16}, 32'h0);
                end
            end
            if (overrun_err16) begin
                checkOutput("overrun_err16", 32'h1, 32'h0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_tvalid8", {31'h0, tvalid8}, 32'h0);
        checkOutput("reset_tdata8", {24'h0, tdata8}, 32'h0);
        checkOutput("reset_rx_done8", {31'h0, rx_done8}, 32'h0);
        checkOutput("reset_errs8", {29'h0, parity_err8, frame_err8, overrun_err8}, 32'h0);
        checkOutput("reset_tvalid16", {31'h0, tvalid16}, 32'h0);
        checkOutput("reset_tdata16", {16'h0, tdata16}, 32'h0);
        @(posedge aclk);
        #1;
        areset8  = 1'b0;
        areset16 = 1'b0;
        repeat (5) @(posedge aclk);

        // Clean byte, correct odd parity.
        pushWord8(8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hA5, 1'b1, 1'b1);

        // Three-clock low glitch must be rejected, then a good frame.
        @(posedge aclk);
        #1;
        driveLine(1'b0, 1'b0, 3);
        driveLine(1'b0, 1'b1, 3 * BIT_CLKS);
        checkOutput("glitch_tvalid8", {31'h0, tvalid8}, 32'h0);
        pushWord8(8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1);

        // Wrong parity bit.
        pushWord8(8'h0F, PCHK, 1'b0);
        applyStimulus(1'b0, 8'h0F, 1'b0, 1'b1);

        // Low stop bit, then a clean frame right after.
        pushWord8(8'h55, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h55, 1'b1, 1'b0);
        pushWord8(8'h01, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h01, 1'b0, 1'b1);

        // Backpressure: the second word is dropped and the first is held.
        tready8 = 1'b0;
        pushWord8(8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h11, 1'b1, 1'b1);
        ovr_exp++;
        applyStimulus(1'b0, 8'h22, 1'b1, 1'b1);
        @(negedge aclk);
        checkOutput("held_tvalid8", {31'h0, tvalid8}, 32'h1);
        checkOutput("held_tdata8", {24'h0, tdata8}, 32'h11);
        checkOutput("overrun_count", ovr_seen, ovr_exp);
        @(posedge aclk);
        #1;
        tready8 = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("drained_tvalid8", {31'h0, tvalid8}, 32'h0);

        // Two bytes packed into one 16-bit word.
        pushWord16(16'h1234);
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b1);

        // Reset after one byte discards the partial word.
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b1);
        @(posedge aclk);
        #1;
        areset16 = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset16 = 1'b0;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        checkOutput("post_reset_tvalid16", {31'h0, tvalid16}, 32'h0);
        pushWord16(16'hABCD);
        applyStimulus(1'b1, 8'hAB, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hCD, 1'b0, 1'b1);

        repeat (20) @(posedge aclk);
        @(negedge aclk);
        checkOutput("done8_q_drained", done8_q.size(), 32'h0);
        checkOutput("hs8_q_drained", hs8_q.size(), 32'h0);
        checkOutput("done16_q_drained", done16_q.size(), 32'h0);
        checkOutput("overrun_total", ovr_seen, ovr_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
